// File: rtl/vga_fb_scanout_200x150x4.sv
// 200x150x4 framebuffer scanned out as 4x4 pixel blocks on the 800x600 VGA path.
// Fixed 3-cycle pixel latency with matching sync delay; valid/ready loader port and full-frame clear engine.
module vga_fb_scanout_200x150x4 #(
    parameter int unsigned FB_W      = 200,
    parameter int unsigned FB_H      = 150,
    parameter string       INIT_FILE = ""
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_de,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [1:0] o_red,
    output logic [1:0] o_green,
    output logic [1:0] o_blue,
    output logic       o_hsync,
    output logic       o_vsync,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [7:0] i_wr_x,
    input  logic [7:0] i_wr_y,
    input  logic [3:0] i_wr_color,
    output logic       o_wr_err,
    input  logic       i_clear,
    input  logic [3:0] i_clear_color,
    output logic       o_busy
);

    localparam int unsigned DEPTH     = FB_W * FB_H;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  W8        = 8'(FB_W);
    localparam logic [7:0]  H8        = 8'(FB_H);

    typedef enum logic {IDLE, CLEAR} state_t;

    // row*200 + col built from shifts (128+64+8) so no multiplier is inferred
    function automatic logic [14:0] cell_addr(input logic [7:0] cx, input logic [7:0] cy);
        return {cy, 7'b0} + {1'b0, cy, 6'b0} + {4'b0, cy, 3'b0} + {7'b0, cx};
    endfunction

    function automatic logic [1:0] chan(input logic on, input logic inten);
        return on ? {1'b1, inten} : 2'b00;
    endfunction

    state_t      state, state_nx;
    logic        ready_nx, busy_nx;
    logic [14:0] clr_addr;
    logic [3:0]  clr_color;

    logic        wr_accept, wr_in_range;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [3:0]  wr_data;

    logic [3:0]  mem [DEPTH];
    logic [14:0] scan_addr;
    logic [3:0]  rd_data;
    logic [1:0]  de_p, hs_p, vs_p;

    assign wr_accept   = i_wr_valid & o_wr_ready;
    assign wr_in_range = (i_wr_x < W8) && (i_wr_y < H8);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_clear) state_nx = CLEAR;
            CLEAR:   if (clr_addr == LAST_ADDR) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready_nx = (state_nx == IDLE);
        busy_nx  = (state_nx == CLEAR);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_ready <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_err   <= 1'b0;
            clr_addr   <= '0;
            clr_color  <= '0;
        end else begin
            o_wr_ready <= ready_nx;
            o_busy     <= busy_nx;
            o_wr_err   <= wr_accept & ~wr_in_range;
            if (state == IDLE && i_clear) begin
                clr_addr  <= '0;
                clr_color <= i_clear_color;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + 15'd1;
            end
        end
    end

    // Clear engine owns the write port while active; loader writes only go through in IDLE
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cell_addr(i_wr_x, i_wr_y);
        wr_data = i_wr_color;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = clr_color;
        end else if (wr_accept && wr_in_range) begin
            wr_en = 1'b1;
        end
    end

    // Read and write share one block so a same-address collision returns the old cell
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[scan_addr];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scan_addr <= '0;
            de_p      <= '0;
            hs_p      <= '0;
            vs_p      <= '0;
            o_hsync   <= 1'b0;
            o_vsync   <= 1'b0;
            o_red     <= '0;
            o_green   <= '0;
            o_blue    <= '0;
        end else begin
            if (i_de) scan_addr <= cell_addr(i_x[9:2], i_y[9:2]);
            de_p    <= {de_p[0], i_de};
            hs_p    <= {hs_p[0], i_hsync};
            vs_p    <= {vs_p[0], i_vsync};
            o_hsync <= hs_p[1];
            o_vsync <= vs_p[1];
            if (de_p[1]) begin
                o_red   <= chan(rd_data[2], rd_data[3]);
                o_green <= chan(rd_data[1], rd_data[3]);
                o_blue  <= chan(rd_data[0], rd_data[3]);
            end else begin
                o_red   <= '0;
                o_green <= '0;
                o_blue  <= '0;
            end
        end
    end

endmodule
